// File: rtl/ahb_fabric_verif_param_pkg.sv
// rtl/ahb_fabric_verif_param_pkg.sv - default bus widths for the AHB fabric arbiter
package ahb_fabric_verif_param_pkg;
    parameter int HADDR = 32;
    parameter int HDATA = 32;
endpackage

// File: rtl/ahb_fabric_arb.sv
// rtl/ahb_fabric_arb.sv - round-robin AHB-lite multi-master to single-slave arbiter
module ahb_fabric_arb #(
    parameter int HADDR   = ahb_fabric_verif_param_pkg::HADDR,
    parameter int HDATA   = ahb_fabric_verif_param_pkg::HDATA,
    parameter int NUM_MST = 2
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [2*NUM_MST-1:0]     m_htrans,
    input  logic [HADDR*NUM_MST-1:0] m_haddr,
    input  logic [NUM_MST-1:0]       m_hwrite,
    input  logic [3*NUM_MST-1:0]     m_hsize,
    input  logic [HDATA*NUM_MST-1:0] m_hwdata,
    input  logic [NUM_MST-1:0]       m_hmastlock,
    output logic [NUM_MST-1:0]       m_hready,
    output logic [NUM_MST-1:0]       m_hresp,
    output logic [HDATA-1:0]         m_hrdata,
    output logic [1:0]               s_htrans,
    output logic [HADDR-1:0]         s_haddr,
    output logic                     s_hwrite,
    output logic [2:0]               s_hsize,
    output logic                     s_hmastlock,
    output logic [HDATA-1:0]         s_hwdata,
    input  logic                     s_hready,
    input  logic                     s_hresp,
    input  logic [HDATA-1:0]         s_hrdata,
    output logic [2:0]               addr_owner,
    output logic [2:0]               data_owner
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic [2:0]       a_own;
    logic [2:0]       d_own;
    logic             d_valid;

    logic [1:0]       a_trans;
    logic [HADDR-1:0] a_addr;
    logic             a_write;
    logic [2:0]       a_size;
    logic             a_lock;
    logic [HDATA-1:0] d_wdata;
    logic             releasable;
    logic             found;
    logic [2:0]       next_own;

    // Select the address-phase owner's signals and the data-phase owner's write data
    always_comb begin
        a_trans = TRANS_IDLE;
        a_addr  = '0;
        a_write = 1'b0;
        a_size  = 3'b000;
        a_lock  = 1'b0;
        d_wdata = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (a_own == 3'(i)) begin
                a_trans = m_htrans[2*i +: 2];
                a_addr  = m_haddr[HADDR*i +: HADDR];
                a_write = m_hwrite[i];
                a_size  = m_hsize[3*i +: 3];
                a_lock  = m_hmastlock[i];
            end
            if (d_own == 3'(i)) begin
                d_wdata = m_hwdata[HDATA*i +: HDATA];
            end
        end
    end

    // Round-robin search for the first NONSEQ requester after the current owner
    always_comb begin
        found    = 1'b0;
        next_own = a_own;
        for (int j = 1; j < NUM_MST; j++) begin
            if (!found && m_htrans[2*((int'(a_own) + j) % NUM_MST) +: 2] == TRANS_NONSEQ) begin
                found    = 1'b1;
                next_own = 3'((int'(a_own) + j) % NUM_MST);
            end
        end
    end

    assign releasable  = (a_trans == TRANS_IDLE) && !a_lock;

    assign s_htrans    = HRESET ? TRANS_IDLE : a_trans;
    assign s_haddr     = a_addr;
    assign s_hwrite    = a_write;
    assign s_hsize     = a_size;
    assign s_hmastlock = a_lock;
    assign s_hwdata    = d_wdata;
    assign m_hrdata    = s_hrdata;
    assign addr_owner  = a_own;
    assign data_owner  = d_own;

    // Ownership hand-off and pipeline advance; nothing moves while the slave stalls
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_own   <= 3'd0;
            d_own   <= 3'd0;
            d_valid <= 1'b0;
        end else if (s_hready) begin
            if (releasable && found) begin
                a_own <= next_own;
            end
            d_own   <= a_own;
            d_valid <= s_htrans[1];
        end
    end

    // Route ready/response to owners; stall waiting requesters, let idle masters run free
    always_comb begin
        m_hready = '1;
        m_hresp  = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (!HRESET) begin
                if (a_own == 3'(i) || (d_valid && d_own == 3'(i))) begin
                    m_hready[i] = s_hready;
                end else begin
                    m_hready[i] = (m_htrans[2*i +: 2] == TRANS_IDLE);
                end
                if (d_valid && d_own == 3'(i)) begin
                    m_hresp[i] = s_hresp;
                end
            end
        end
    end

endmodule

// File: doc/ahb_fabric_arb.md
AHB_FABRIC_ARB -- requirements
Module: ahb_fabric_arb

Interface
REQ-001 Parameter HADDR, default ahb_fabric_verif_param_pkg::HADDR, address width.
REQ-002 Parameter HDATA, default ahb_fabric_verif_param_pkg::HDATA, data width.
REQ-003 Parameter NUM_MST, default 2, number of AHB-lite masters; legal range 2..8.
REQ-004 HCLK  in  1  sole clock; all state updates on rising edge.
REQ-005 HRESET  in  1  synchronous, active-high reset.
REQ-006 m_htrans  in  2*NUM_MST  per-master HTRANS; slice i is [2i+1:2i].
REQ-007 m_haddr  in  HADDR*NUM_MST  per-master HADDR.
REQ-008 m_hwrite  in  NUM_MST  per-master HWRITE.
REQ-009 m_hsize  in  3*NUM_MST  per-master HSIZE.
REQ-010 m_hwdata  in  HDATA*NUM_MST  per-master HWDATA.
REQ-011 m_hmastlock  in  NUM_MST  per-master HMASTLOCK.
REQ-012 m_hready  out  NUM_MST  per-master HREADY.
REQ-013 m_hresp  out  NUM_MST  per-master HRESP.
REQ-014 m_hrdata  out  HDATA  shared read data, equal to s_hrdata.
REQ-015 s_htrans, s_haddr, s_hwrite, s_hsize, s_hmastlock  out  2/HADDR/1/3/1  muxed slave address phase.
REQ-016 s_hwdata  out  HDATA  muxed write data, taken from the data-phase owner.
REQ-017 s_hready, s_hresp, s_hrdata  in  1/1/HDATA  slave response.
REQ-018 addr_owner, data_owner  out  3 each  current address-phase and data-phase owner index.

Function
REQ-019 The block SHALL hold registers a_own (address owner), d_own (data owner) and d_valid.
REQ-020 Address-phase outputs s_* SHALL be a combinational mux of master a_own; s_hwdata SHALL be a combinational mux of master d_own.
REQ-021 A master i SHALL be "requesting" when m_htrans[i] is NONSEQ (2'b10).
REQ-022 a_own SHALL be "releasable" when m_htrans[a_own] is IDLE and m_hmastlock[a_own]=0.
REQ-023 On an edge with s_hready=1, a releasable a_own, and at least one other master requesting, a_own SHALL take the first requesting index after a_own in round-robin order (wrapping from NUM_MST-1 to 0).
REQ-024 a_own SHALL NOT change during SEQ or BUSY, while hmastlock=1 (including IDLE+lock), or while s_hready=0.
REQ-025 With no other requester, a_own SHALL park on its current value.
REQ-026 On an edge with s_hready=1: d_own<=a_own, d_valid<=s_htrans[1]; with s_hready=0 both SHALL hold.
REQ-027 m_hready[i] SHALL equal s_hready when i==a_own or (d_valid and i==d_own); otherwise 1 if m_htrans[i] is IDLE, else 0 (stall non-granted requester).
REQ-028 m_hresp[i] SHALL equal s_hresp when d_valid and i==d_own, else 0.
REQ-029 Grant latency: a non-owner NONSEQ presented while the owner is releasable and s_hready=1 SHALL appear on s_htrans exactly one cycle later.
REQ-030 Simultaneous requests SHALL be resolved strictly by round-robin; no master SHALL wait more than NUM_MST-1 ownership changes.
REQ-031 ERROR responses SHALL pass through unmodified over both cycles; ownership rules are unchanged by ERROR.
REQ-032 Owner indices beyond NUM_MST-1 SHALL be unreachable; output width SHALL be 3 irrespective of NUM_MST.

Reset
REQ-033 While HRESET=1 on an edge: a_own<=0, d_own<=0, d_valid<=0.
REQ-034 While HRESET=1, s_htrans SHALL be forced IDLE and all m_hready SHALL be 1, m_hresp 0.
REQ-035 Reset asserted mid-burst SHALL abandon the burst; the first post-reset cycle SHALL have a_own=0 and no data phase pending.

Verification
REQ-036 Reset, all masters IDLE -> s_htrans=IDLE, m_hready all 1, addr_owner=0, data_owner=0.
REQ-037 NUM_MST=4, masters 1,2,3 NONSEQ from cycle t with owner 0 IDLE -> ownership order 1,2,3, each switch one cycle after the prior owner returns IDLE; waiting masters see m_hready=0.
REQ-038 Master 0 INCR4 burst with master 1 requesting at beat 2 -> no switch until master 0 IDLE after beat 4; master 1 granted the next cycle.
REQ-039 Master 0 hmastlock=1 with IDLE between two transfers, master 1 requesting -> a_own stays 0 until lock drops.
REQ-040 Slave inserts 2 wait states (s_hready=0) on master 1's data phase with master 0's address pending -> d_own/a_own hold, s_hwdata stays master 1's data, only masters 0/1 see s_hready.
REQ-041 Slave ERROR (two cycles) to master 2 -> m_hresp[2]=1 both cycles, other m_hresp=0; HRESET in the second cycle -> REQ-035 state next cycle.
